// File: rtl/sha2_w_schedule_stream.sv
// SHA-2 message schedule: loads a 16-word block and streams W_0..W_{ROUNDS-1}
// through a sliding 16-word window with valid/ready flow control.
module sha2_w_schedule_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORD_W-1:0]  block_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_w,
    output logic [CNT_W-1:0]      out_t,
    output logic                  out_last
);

    if (!((WORD_W == 32 && ROUNDS == 64) ||
          (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
        $error("sha2_w_schedule_stream: illegal WORD_W/ROUNDS pair");
    end
    if (ROUNDS > (1 << CNT_W)) begin : g_bad_cnt
        $error("sha2_w_schedule_stream: CNT_W too narrow for ROUNDS");
    end

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(ROUNDS - 1);

    logic              state;
    logic [WORD_W-1:0] win [16];
    logic [CNT_W-1:0]  t;
    logic [WORD_W-1:0] w_new;
    logic              hs;
    logic              load;

    function automatic logic [WORD_W-1:0] rotr(
        input logic [WORD_W-1:0] x,
        input int                n
    );
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else              return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    assign out_valid = (state == RUN);
    assign out_w     = win[0];
    assign out_t     = t;
    assign out_last  = out_valid && (t == T_LAST);
    assign hs        = out_valid && out_ready;
    // A last-word handshake frees the window, so a new block may load on that edge.
    assign in_ready  = !RST && !flush && (state == IDLE || (hs && out_last));
    assign load      = in_valid && in_ready;

    // Window slot 0 holds W_t, so W_{t+16} uses offsets 14, 9, 1 and 0.
    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            t     <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (flush) begin
            state <= IDLE;
            t     <= '0;
        end else if (load) begin
            state <= RUN;
            t     <= '0;
            for (int i = 0; i < 16; i++)
                win[i] <= block_in[(15-i)*WORD_W +: WORD_W];
        end else if (hs) begin
            if (out_last) begin
                state <= IDLE;
            end else begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_new;
                t       <= t + 1'b1;
            end
        end
    end

endmodule

// File: doc/sha2_w_schedule_stream.md
Name: sha2_w_schedule_stream

Overview:
Parametrised SHA-2 message-schedule engine. It accepts one 16-word padded message block and streams the round words W_0..W_{ROUNDS-1}, one per handshake, to a round-compression core. It generalises the fixed single-stage SHA-256 W-expansion to both SHA-256 and SHA-512 word sizes. It adds a sliding 16-word window with round counter, valid/ready flow control on both sides, back-to-back block acceptance and a flush.

Parameters:
WORD_W, 32, word width. Legal values are 32 (SHA-256) and 64 (SHA-512); any other value is an elaboration error.
ROUNDS, 64, number of W words emitted per block. Must be 64 when WORD_W=32 and 80 when WORD_W=64; a mismatch is an elaboration error.
CNT_W, 7, width of the round index output (must hold ROUNDS-1).

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
flush  in  1  synchronous abort of current block, lower priority than RST
in_valid  in  1  block_in valid
in_ready  out  1  engine can accept a block this cycle
block_in  in  16*WORD_W  message block; W_0 = block_in[16*WORD_W-1 -: WORD_W], W_15 = block_in[WORD_W-1:0]
out_valid  out  1  out_w valid
out_ready  in  1  consumer accepts out_w
out_w  out  WORD_W  current schedule word W_t
out_t  out  CNT_W  round index t of out_w
out_last  out  1  high with out_valid when t = ROUNDS-1

Behaviour:
- State: FSM {IDLE, RUN}, a 16-entry window win[0..15] of WORD_W bits, and round counter t.
  - out_w = win[0]; out_t = t; out_valid = (state==RUN); out_last = out_valid && (t==ROUNDS-1).
- Reset:
  - RST high at an edge: state=IDLE, t=0, all window entries 0.
  - Hence out_valid=0, out_last=0, out_w=0, out_t=0.
  - in_ready is forced 0 while RST is high.
  - A reset mid-block discards that block with no further output.
- in_ready = !RST && !flush && (state==IDLE || (out_valid && out_ready && out_last)). This is a combinational path from out_ready.
- Load: in_valid && in_ready at edge N loads win[i] = W_i and sets t=0, state=RUN. W_0 appears on out_w in cycle N+1 (latency 1). block_in is not sampled at any other time.
- Advance: on each out_valid && out_ready with t < ROUNDS-1:
  - win[i] <= win[i+1] for i = 0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^WORD_W; carries are discarded.
  - t <= t+1.
- Sigma functions:
  - WORD_W=32: sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: sigma0 = ROTR1^ROTR8^SHR7; sigma1 = ROTR19^ROTR61^SHR6.
- Last word: a handshake with out_last ends the block.
  - If a new block is accepted on the same edge (zero-bubble back-to-back), it loads and the next cycle shows W_0 of the new block with t=0.
  - Otherwise state goes to IDLE.
- Backpressure: while out_valid && !out_ready, the window, t, out_w, out_t and out_last hold unchanged for any number of cycles.
- Flush: flush high at an edge (RST low) gives state=IDLE, t=0, with the window contents don't-care.
  - flush with in_valid on the same edge: the block is not accepted (in_ready=0).
  - flush with an out handshake on the same edge: the word counts as consumed, but the engine still goes IDLE.
- Priority: RST > flush > load/advance.
- Counter t never exceeds ROUNDS-1 and never wraps inside a block.

Test Plan:
1. SHA-256 "abc" block (W_0=0x61626380, W_1..W_14=0, W_15=0x00000018), out_ready=1 → 64 words in 64 consecutive cycles starting one cycle after the load. W_16=0x61626380, W_17=0x000F0000, out_last only at t=63, and all 64 words match the golden model.
2. WORD_W=64, ROUNDS=80, "abc" block (W_0=0x6162638000000000, W_15=0x18) → W_16=0x6162638000000000, W_17=0x00030000000000C0, 80 words with out_last at t=79, matching the model.
3. Backpressure: out_ready low for 3 cycles while out_t=5, plus random out_ready over a full block → out_w/out_t stable during every stall, and the word sequence is identical to test 1 with no drops or duplicates.
4. Back-to-back: second block held valid during the first block's t=63 handshake → in_ready=1 on that cycle, and the next cycle shows out_t=0 with the second block's W_0, with no idle cycle.
5. Flush at t=20 together with in_valid=1 → next cycle out_valid=0, block not accepted. Next cycle in_ready=1, and a new load gives the correct W_0.
6. RST asserted at t=30 → next cycle out_valid=0, out_w=0, out_t=0, and in_ready=0 during RST. After release, in_ready=1 and a fresh "abc" block reproduces test 1 exactly.
